// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial, LSB-first unsigned subtractor: diff = a - b mod 2^WIDTH, one bit
// per clock through a single registered borrow. A start/busy/done handshake
// lets a control FSM issue operations and collect diff and the final borrow.
//
// Timing (accepting start edge = edge 0):
//   edges 1..WIDTH  : SHIFT, one result bit per edge, busy = 1
//   after edge WIDTH: diff/borrow_out updated, done = 1 for one cycle (DONE)
//   DONE accepts a new start, so back-to-back throughput is WIDTH+1 cycles.
//
// Optional feature (compile-time macro SERIAL_SUBTRACTOR_ADD_MODE_EN):
//   adds a 1-bit `mode` input captured on accepted start. mode=1 subtracts,
//   mode=0 adds and borrow_out then reports the carry out. Without the macro
//   the port is absent and the block only subtracts.
//
// WIDTH legal range: 2..32.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Counter wide enough to hold 0..WIDTH-1; the final SHIFT edge is the one
    // taken while the counter reads WIDTH-1.
    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;     // minuend, consumed LSB first
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;     // subtrahend, consumed LSB first
    logic [WIDTH-1:0]   work_q, work_d;     // result bits enter at the MSB
    logic               bor_q, bor_d;       // running borrow (or carry)
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // SHIFT edges taken so far
    logic [WIDTH-1:0]   diff_q, diff_d;     // last completed result
    logic               borrow_q, borrow_d; // last completed final borrow

    logic               start_accept;
    logic               sub_sel;            // 1 = subtract, 0 = add
    logic               a_bit, b_bit, p_bit;
    logic               d_bit;
    logic               bor_next;

    // A request is honoured in IDLE and in DONE; while shifting it is ignored.
    assign start_accept = start && (state_q != ST_SHIFT);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic mode_q, mode_d;

    // Operation direction is frozen for the whole operation at start.
    always_comb begin
        mode_d = mode_q;
        if (start_accept) begin
            mode_d = mode;
        end
    end

    // Mode register; cleared to subtract-off (add) state on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign sub_sel = mode_q;
`else
    assign sub_sel = 1'b1;
`endif

    // Single-bit full subtractor / full adder slice on the current LSBs.
    always_comb begin
        a_bit = a_sh_q[0];
        b_bit = b_sh_q[0];
        p_bit = a_bit ^ b_bit;
        d_bit = p_bit ^ bor_q;
        if (sub_sel) begin
            bor_next = (~a_bit & b_bit) | (~p_bit & bor_q);
        end else begin
            bor_next = (a_bit & b_bit) | (bor_q & p_bit);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        work_d   = work_q;
        bor_d    = bor_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_accept) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    work_d  = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                work_d = {d_bit, work_q[WIDTH-1:1]};
                bor_d  = bor_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Publish using the bit computed this very edge.
                    diff_d   = {d_bit, work_q[WIDTH-1:1]};
                    borrow_d = bor_next;
                    state_d  = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift and work registers are ordinary flops, not a
            // memory, so clearing them on reset is cheap and keeps every
            // observable value defined after an aborted operation.
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            work_q   <= '0;
            bor_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            work_q   <= work_d;
            bor_q    <= bor_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Handshake outputs decode directly from the registered state.
    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule
